// File: rtl/cbus_arbiter.sv
// Shares one cbus port between ibus and dbus: 1-cycle grant latency, 0-cycle response path,
// grant held until ready&&last; non-granted requester simply waits (no ready) until next IDLE.
package cbus_pkg;
   typedef struct packed {
      logic        valid;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;
endpackage

module cbus_arbiter
   import cbus_pkg::*;
#(
   parameter int STARVE_LIMIT = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  cbus_req_t  ireq,
   output cbus_resp_t iresp,
   input  cbus_req_t  dreq,
   output cbus_resp_t dresp,
   output cbus_req_t  oreq,
   input  cbus_resp_t oresp,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t     state, state_nxt;
   logic [3:0] starve_cnt, starve_nxt;
   logic       done;

   assign done = oresp.ready && oresp.last;
   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         starve_cnt <= 4'd0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      starve_nxt = starve_cnt;
      oreq       = '0;
      iresp      = '0;
      dresp      = '0;
      case (state)
         IDLE: begin
            // Arbitration only here, so a completion never races a new grant.
            if (ireq.valid && (!dreq.valid || starve_cnt == LIMIT)) begin
               state_nxt  = GNT_I;
               starve_nxt = 4'd0;
            end else if (dreq.valid) begin
               state_nxt = GNT_D;
               if (ireq.valid && starve_cnt < LIMIT)
                  starve_nxt = starve_cnt + 4'd1;
            end
         end
         GNT_I: begin
            oreq  = ireq;
            iresp = oresp;
            if (done)
               state_nxt = IDLE;
         end
         GNT_D: begin
            oreq  = dreq;
            dresp = oresp;
            if (done)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: doc/cbus_arbiter.md
# cbus_arbiter

Two-port arbiter that shares the single core-side cbus port of the address-translation/memory unit between instruction fetch (ibus) and the load/store stage (dbus). It grants one requester per transaction, holds the grant across the full page-table walk and the final access, and routes the response back to the granted requester only. Data requests have priority. A starvation counter guarantees instruction fetch progress. The block sits between the core's two bus masters and the translation unit.

## Interface
- STARVE_LIMIT, default 2: number of consecutive dbus grants, each with ibus waiting, after which ibus wins the next contested arbitration; legal range 1..15.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ireq  in  cbus_req_t  instruction-fetch request.
- iresp  out  cbus_resp_t  instruction-fetch response.
- dreq  in  cbus_req_t  load/store request.
- dresp  out  cbus_resp_t  load/store response.
- oreq  out  cbus_req_t  request to the translation unit.
- oresp  in  cbus_resp_t  response from the translation unit.
- busy  out  1  high while in GNT_I or GNT_D.

## Operation
- States: IDLE, GNT_I, GNT_D. A registered 2-bit state plus a registered starve_cnt (4 bits).
- Arbitration in IDLE, evaluated from ireq.valid and dreq.valid in that cycle:
  - Neither valid: stay in IDLE.
  - Only one valid: go to that requester's grant state.
  - Both valid and starve_cnt == STARVE_LIMIT: go to GNT_I.
  - Both valid otherwise: go to GNT_D.
- starve_cnt update, applied on the IDLE→GNT transition:
  - GNT_D entered while ireq.valid = 1: starve_cnt increments, saturating at STARVE_LIMIT.
  - GNT_I entered: starve_cnt clears to 0.
  - All other transitions: starve_cnt holds.
- In GNT_x:
  - oreq is a combinational copy of the granted requester's request, all fields.
  - The granted response port is a combinational copy of oresp (ready, last, data).
  - The non-granted response port drives all zeros.
- Transaction end: oresp.ready && oresp.last while in GNT_x → next state IDLE. Intermediate page-table beats never reach the core-side unit as completions, so only the final beat ends the grant.
- In IDLE: oreq, iresp and dresp are all zero. oreq.valid is forced to 0 in IDLE even if a requester is valid.
- Requester obligations, which the verification bench checks with assertions:
  - A requester holds its request stable from valid until it sees ready && last.
  - The translation unit reads the request address throughout the table walk, so a changed request corrupts the walk.
  - If the granted requester drops valid mid-grant, the arbiter keeps the grant until completion. No abort exists.
- Responses arriving in IDLE (oresp.ready = 1) are dropped.

## Timing
- Reset (rst_n = 0, any cycle including mid-transaction):
  - state = IDLE, starve_cnt = 0.
  - oreq, iresp and dresp all zero; busy = 0.
  - An in-flight downstream transaction is abandoned; the translation unit is reset by the same reset.
- Request latency: a request valid in an IDLE cycle at edge N appears on oreq.valid from edge N+1. This is one cycle of arbitration latency.
- Response latency: zero cycles. iresp/dresp.ready is asserted in the same cycle as oresp.ready.
- Turnaround:
  - After the completing beat (edge M), the state is IDLE for cycle M+1.
  - The earliest next grant is visible at edge M+2.
  - This guaranteed dead cycle lets the requester drop valid before it can be re-granted, so a duplicate access cannot be issued.
- Back-to-back, same requester, valid continuously: one transaction per (downstream latency + 2) cycles.
- Simultaneous completion and new request: cannot occur in a grant state, because arbitration happens only in IDLE.

## Test plan
- Reset mid-transaction: grant dreq, drop rst_n with oresp idle → next cycle oreq.valid = 0, busy = 0, starve_cnt = 0; after release, a pending ireq is granted after 1 IDLE cycle.
- Single ibus fetch: ireq.valid = 1, addr = 0x8000_0000, downstream returns data 0x1234_5678 with ready/last 6 cycles later → oreq.addr = 0x8000_0000 from cycle 1; iresp.data = 0x1234_5678 in the same cycle; dresp stays zero; busy falls the next cycle.
- Multi-beat walk: downstream emits three ready beats with last = 0, then one with last = 1 → grant held through all four beats; state returns to IDLE only after the last beat.
- Contention with STARVE_LIMIT = 2: ireq and dreq both held valid continuously → grant order D, D, I, D, D, I; a dead IDLE cycle between every grant.
- Granted dreq drops valid mid-grant → oreq stays sourced from dreq; dresp still pulses ready on completion; no ibus grant until after the following IDLE cycle.
- Stray response: oresp.ready = 1 while in IDLE → iresp and dresp both remain zero; state stays IDLE.
